cache: RTL and testbench



---
 rtl/cache.sv | 165 ++++++++++++++++
 tb/tb_cache.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines of 128 bits between the
// LC-3b memory port and a line-granular physical memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits with a zero-latency mem_resp; detect misses
// WRITEBACK | push the dirty victim line out to physical memory
// FILL      | fetch the requested line from physical memory

module cache (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [127:0] data_q [8];
    logic [8:0]   tag_q  [8];
    logic [7:0]   valid_q;
    logic [7:0]   dirty_q;

    logic [8:0]   req_tag;
    logic [2:0]   idx;
    logic [2:0]   off;
    logic         req;
    logic         is_write;
    logic         hit;
    logic [127:0] cur_line;
    logic [15:0]  cur_word;
    logic [15:0]  merged_word;
    logic [127:0] merged_line;
    logic         do_write_hit;
    logic         do_fill;
    logic         do_wb_done;
    logic         unused_addr_bit;

    // Byte placement comes only from the mask, so address bit 0 carries no information.
    assign unused_addr_bit = mem_address[0];

    assign req_tag  = mem_address[15:7];
    assign idx      = mem_address[6:4];
    assign off      = mem_address[3:1];
    assign req      = mem_read | mem_write;
    assign is_write = mem_write;
    assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        cur_line    = data_q[idx];
        cur_word    = cur_line[{off, 4'b0000} +: 16];
        merged_word = {mem_byte_enable[1] ? mem_wdata[15:8] : cur_word[15:8],
                       mem_byte_enable[0] ? mem_wdata[7:0]  : cur_word[7:0]};
        merged_line = cur_line;
        merged_line[{off, 4'b0000} +: 16] = merged_word;
    end

    always_comb begin
        state_d      = state_q;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_address = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        do_write_hit = 1'b0;
        do_fill      = 1'b0;
        do_wb_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (is_write) begin
                            do_write_hit = 1'b1;
                        end else begin
                            mem_rdata = cur_word;
                        end
                    end else if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx], idx, 4'b0000};
                pmem_wdata   = cur_line;
                if (pmem_resp) begin
                    do_wb_done = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[15:4], 4'b0000};
                if (pmem_resp) begin
                    do_fill = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            if (do_fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (do_wb_done) begin
                dirty_q[idx] <= 1'b0;
            end
            if (do_write_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Data and tags are left uninitialised; a cleared valid bit makes them irrelevant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (do_fill) begin
                data_q[idx] <= pmem_rdata;
                tag_q[idx]  <= req_tag;
            end else if (do_write_hit) begin
                data_q[idx] <= merged_line;
            end
        end
    end

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache: stimulus queues expected CPU and pmem responses,
// independent monitors pop and compare them when the DUT presents a response.

module tb_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp;
    logic         model_resp = 1'b0;
    logic         late_resp  = 1'b0;

    assign pmem_resp = model_resp | late_resp;

    always #5 clk = ~clk;

    cache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    typedef struct {
        logic        is_read;
        logic [15:0] rdata;
    } cpu_exp_t;

    typedef struct {
        logic         is_write;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } pm_exp_t;

    cpu_exp_t     cpu_q[$];
    pm_exp_t      pm_q[$];
    logic [127:0] pmem_mem [logic [15:0]];
    int           pmem_lat = 3;
    int           wait_cnt = 0;
    int           total = 0;
    int           bad = 0;

    localparam logic [127:0] LINE_040     = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                             16'h3333, 16'h3456, 16'hBEEF, 16'h1111};
    localparam logic [127:0] LINE_040_MOD = {16'h7777, 16'h6666, 16'h5555, 16'h4444,
                                             16'h3333, 16'h1256, 16'hBEEF, 16'h1111};
    localparam logic [127:0] LINE_840     = {112'h0, 16'hA5A5};
    localparam logic [127:0] LINE_1230    = {96'h0, 16'hCAFE, 16'h7700};
    localparam logic [127:0] LINE_1230_MOD = {96'h0, 16'h5A5A, 16'h77CD};
    localparam logic [127:0] LINE_2000    = {112'h0, 16'h2468};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_pm(input logic is_write, input logic [15:0] addr, input logic [127:0] wdata);
        pm_exp_t e;
        e.is_write = is_write;
        e.addr     = addr;
        e.wdata    = wdata;
        pm_q.push_back(e);
    endtask

    task automatic cpu_req(input logic [15:0] addr, input logic rd, input logic wr,
                           input logic [1:0] be, input logic [15:0] wd,
                           input logic [15:0] exp_rd, input int exp_lat);
        cpu_exp_t e;
        int       cyc;
        bit       got;
        cyc = 0;
        got = 1'b0;
        e.is_read = rd && !wr;
        e.rdata   = exp_rd;
        cpu_q.push_back(e);
        @(posedge clk);
        #1;
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (mem_resp) got = 1'b1;
            else cyc++;
        end
        if (!got) begin
            check("mem_resp timeout", 0, 1);
            if (cpu_q.size() > 0) e = cpu_q.pop_back();
        end else begin
            check("latency", cyc, exp_lat);
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // CPU-side monitor
    always @(negedge clk) begin : cpu_mon
        cpu_exp_t ce;
        if (mem_resp) begin
            if (cpu_q.size() == 0) begin
                check("unexpected mem_resp", 1, 0);
            end else begin
                ce = cpu_q.pop_front();
                if (ce.is_read) check("mem_rdata", mem_rdata, ce.rdata);
            end
        end
    end

    // Physical memory model and monitor: responds pmem_lat cycles into each request
    always @(negedge clk) begin : pmem_model
        pm_exp_t pe;
        model_resp = 1'b0;
        if (pmem_read || pmem_write) begin
            check("pmem overlap", pmem_read && pmem_write, 0);
            wait_cnt++;
            if (wait_cnt >= pmem_lat) begin
                wait_cnt   = 0;
                model_resp = 1'b1;
                if (pm_q.size() == 0) begin
                    check("unexpected pmem op", 1, 0);
                end else begin
                    pe = pm_q.pop_front();
                    check("pmem op type", pmem_write, pe.is_write);
                    check("pmem_address", pmem_address, pe.addr);
                    if (pe.is_write) check("pmem_wdata", pmem_wdata, pe.wdata);
                end
                if (pmem_write) pmem_mem[pmem_address] = pmem_wdata;
                else pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address] : '0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        mem_address     = 16'h0000;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 2'b11;
        mem_wdata       = 16'h0000;
        pmem_mem[16'h0040] = LINE_040;
        pmem_mem[16'h0840] = LINE_840;
        pmem_mem[16'h1230] = LINE_1230;
        pmem_mem[16'h2000] = LINE_2000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset mem_resp", mem_resp, 0);
        check("reset mem_rdata", mem_rdata, 0);
        check("reset pmem_read", pmem_read, 0);
        check("reset pmem_write", pmem_write, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // clean miss then hit on the same word
        pmem_lat = 3;
        exp_pm(1'b0, 16'h0040, '0);
        cpu_req(16'h0042, 1'b1, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 4);
        cpu_req(16'h0042, 1'b1, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 0);

        // high-byte write hit
        cpu_req(16'h0044, 1'b0, 1'b1, 2'b10, 16'h12AB, 16'h0000, 0);
        cpu_req(16'h0044, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h1256, 0);

        // dirty eviction: writeback of modified 0x0040 line, then fill of 0x0840
        pmem_lat = 2;
        exp_pm(1'b1, 16'h0040, LINE_040_MOD);
        exp_pm(1'b0, 16'h0840, '0);
        cpu_req(16'h0840, 1'b1, 1'b0, 2'b11, 16'h0000, 16'hA5A5, 5);

        // write miss with low-byte mask
        pmem_lat = 3;
        exp_pm(1'b0, 16'h1230, '0);
        cpu_req(16'h1230, 1'b0, 1'b1, 2'b01, 16'h00CD, 16'h0000, 4);
        cpu_req(16'h1230, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h77CD, 0);

        // read and write together act as a write
        cpu_req(16'h1232, 1'b1, 1'b1, 2'b11, 16'h5A5A, 16'h0000, 0);
        cpu_req(16'h1232, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h5A5A, 0);

        // evicting index 3 must write back both merged words
        pmem_lat = 1;
        exp_pm(1'b1, 16'h1230, LINE_1230_MOD);
        exp_pm(1'b0, 16'h12B0, '0);
        cpu_req(16'h12B0, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h0000, 3);

        // reset in the middle of a fill
        pmem_lat = 20;
        @(posedge clk);
        #1;
        mem_address = 16'h2000;
        mem_read    = 1'b1;
        repeat (2) @(negedge clk);
        check("fill pmem_read", pmem_read, 1);
        check("fill pmem_address", pmem_address, 16'h2000);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pmem_read after reset", pmem_read, 0);
        check("mem_resp after reset", mem_resp, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // stray pmem_resp while idle
        @(posedge clk);
        #1 late_resp = 1'b1;
        @(posedge clk);
        #1 late_resp = 1'b0;
        @(negedge clk);
        check("idle pmem_read after stray resp", pmem_read, 0);
        check("idle pmem_write after stray resp", pmem_write, 0);
        check("idle mem_resp after stray resp", mem_resp, 0);

        // valid bits were cleared: both addresses refill
        pmem_lat = 3;
        exp_pm(1'b0, 16'h0040, '0);
        cpu_req(16'h0044, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h1256, 4);
        exp_pm(1'b0, 16'h2000, '0);
        cpu_req(16'h2000, 1'b1, 1'b0, 2'b11, 16'h0000, 16'h2468, 4);

        repeat (3) @(posedge clk);
        check("cpu queue drained", cpu_q.size(), 0);
        check("pmem queue drained", pm_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
